// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at issue, captures RS/LSB
// results, retires one entry per cycle in order and flushes on branch mispredict.
module reorder_buffer #(
  parameter int         ENTRY_SIZE = 4,
  parameter logic [5:0] NULL_REG   = 6'd32
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  issue_valid,
  input  logic [1:0]            issue_type,
  input  logic [5:0]            issue_rd,
  input  logic                  issue_pred_taken,
  input  logic [31:0]           issue_alt_pc,
  output logic                  rob_full,
  output logic [ENTRY_SIZE-1:0] rob_new_entry,
  input  logic                  rs_broadcast,
  input  logic [ENTRY_SIZE-1:0] rs_entry,
  input  logic [31:0]           rs_result,
  input  logic                  rs_taken,
  input  logic                  lsb_broadcast,
  input  logic [ENTRY_SIZE-1:0] lsb_entry,
  input  logic [31:0]           lsb_result,
  input  logic [ENTRY_SIZE-1:0] qj_in,
  input  logic [ENTRY_SIZE-1:0] qk_in,
  output logic                  qj_ready,
  output logic                  qk_ready,
  output logic [31:0]           qj_value,
  output logic [31:0]           qk_value,
  output logic                  rob_commit,
  output logic [ENTRY_SIZE-1:0] rob_entry,
  output logic [5:0]            rob_des,
  output logic [31:0]           rob_result,
  output logic                  store_commit,
  output logic                  roll_back,
  output logic [31:0]           pc_redirect
);

  localparam int                    DEPTH     = 1 << ENTRY_SIZE;
  localparam logic [ENTRY_SIZE-1:0] MAX_TAG   = '1;
  localparam logic [ENTRY_SIZE-1:0] FIRST_TAG = ENTRY_SIZE'(1);
  localparam logic [1:0]            T_BRANCH  = 2'd1;
  localparam logic [1:0]            T_STORE   = 2'd2;

  logic        e_valid  [DEPTH];
  logic        e_ready  [DEPTH];
  logic [1:0]  e_type   [DEPTH];
  logic [5:0]  e_rd     [DEPTH];
  logic        e_pred   [DEPTH];
  logic        e_taken  [DEPTH];
  logic [31:0] e_alt    [DEPTH];
  logic [31:0] e_result [DEPTH];

  logic [ENTRY_SIZE-1:0] head, tail, count;
  logic head_commit, mispredict, do_issue, rs_hit, lsb_hit;

  function automatic logic [ENTRY_SIZE-1:0] next_tag(input logic [ENTRY_SIZE-1:0] t);
    return (t == MAX_TAG) ? FIRST_TAG : t + FIRST_TAG;
  endfunction

  assign rob_full      = (count == MAX_TAG);
  assign rob_new_entry = tail;
  assign head_commit   = e_valid[head] && e_ready[head];
  assign mispredict    = head_commit && (e_type[head] == T_BRANCH) &&
                         (e_taken[head] != e_pred[head]);
  assign do_issue      = issue_valid && !rob_full;
  assign rs_hit        = rs_broadcast && (rs_entry != '0) && e_valid[rs_entry];
  assign lsb_hit       = lsb_broadcast && (lsb_entry != '0) && e_valid[lsb_entry];

  // Operand lookup: stored result first, then same-cycle bypass with RS priority.
  logic [ENTRY_SIZE-1:0] q_tag [2];
  logic                  q_rdy [2];
  logic [31:0]           q_val [2];

  assign q_tag[0] = qj_in;
  assign q_tag[1] = qk_in;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      q_rdy[i] = 1'b0;
      q_val[i] = '0;
      if (q_tag[i] != '0) begin
        if (e_valid[q_tag[i]] && e_ready[q_tag[i]]) begin
          q_rdy[i] = 1'b1;
          q_val[i] = e_result[q_tag[i]];
        end else if (rs_broadcast && rs_entry == q_tag[i]) begin
          q_rdy[i] = 1'b1;
          q_val[i] = rs_result;
        end else if (lsb_broadcast && lsb_entry == q_tag[i]) begin
          q_rdy[i] = 1'b1;
          q_val[i] = lsb_result;
        end
      end
    end
  end

  assign qj_ready = q_rdy[0];
  assign qj_value = q_val[0];
  assign qk_ready = q_rdy[1];
  assign qk_value = q_val[1];

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        e_valid[i]  <= 1'b0;
        e_ready[i]  <= 1'b0;
        e_type[i]   <= '0;
        e_rd[i]     <= NULL_REG;
        e_pred[i]   <= 1'b0;
        e_taken[i]  <= 1'b0;
        e_alt[i]    <= '0;
        e_result[i] <= '0;
      end
      head         <= FIRST_TAG;
      tail         <= FIRST_TAG;
      count        <= '0;
      rob_commit   <= 1'b0;
      store_commit <= 1'b0;
      roll_back    <= 1'b0;
      rob_entry    <= '0;
      rob_des      <= NULL_REG;
      rob_result   <= '0;
      pc_redirect  <= '0;
    end else if (!rdy_in) begin
      rob_commit   <= 1'b0;
      store_commit <= 1'b0;
      roll_back    <= 1'b0;
    end else begin
      rob_commit   <= head_commit;
      store_commit <= head_commit && (e_type[head] == T_STORE);
      roll_back    <= mispredict;
      if (head_commit) begin
        rob_entry  <= head;
        rob_des    <= (e_type[head] == T_BRANCH || e_type[head] == T_STORE) ?
                      NULL_REG : e_rd[head];
        rob_result <= e_result[head];
      end
      if (mispredict) begin
        // Flush wins over any issue or broadcast arriving in the same cycle.
        pc_redirect <= e_alt[head];
        for (int i = 0; i < DEPTH; i++) begin
          e_valid[i] <= 1'b0;
          e_ready[i] <= 1'b0;
        end
        head  <= FIRST_TAG;
        tail  <= FIRST_TAG;
        count <= '0;
      end else begin
        if (rs_hit) begin
          e_ready[rs_entry]  <= 1'b1;
          e_result[rs_entry] <= rs_result;
          e_taken[rs_entry]  <= rs_taken;
        end
        if (lsb_hit) begin
          e_ready[lsb_entry]  <= 1'b1;
          e_result[lsb_entry] <= lsb_result;
        end
        if (do_issue) begin
          e_valid[tail] <= 1'b1;
          e_ready[tail] <= 1'b0;
          e_type[tail]  <= issue_type;
          e_rd[tail]    <= issue_rd;
          e_pred[tail]  <= issue_pred_taken;
          e_taken[tail] <= 1'b0;
          e_alt[tail]   <= issue_alt_pc;
          tail          <= next_tag(tail);
        end
        if (head_commit) begin
          e_valid[head] <= 1'b0;
          head          <= next_tag(head);
        end
        case ({do_issue, head_commit})
          2'b10:   count <= count + FIRST_TAG;
          2'b01:   count <= count - FIRST_TAG;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized
// traffic compared against a queue-based in-order retirement model.
module tb_reorder_buffer;

  localparam logic [5:0] NULL_REG = 6'd32;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, issue_valid, issue_pred_taken;
  logic [1:0]  issue_type;
  logic [5:0]  issue_rd;
  logic [31:0] issue_alt_pc;
  logic        rob_full;
  logic [3:0]  rob_new_entry;
  logic        rs_broadcast, rs_taken, lsb_broadcast;
  logic [3:0]  rs_entry, lsb_entry, qj_in, qk_in;
  logic [31:0] rs_result, lsb_result;
  logic        qj_ready, qk_ready;
  logic [31:0] qj_value, qk_value;
  logic        rob_commit, store_commit, roll_back;
  logic [3:0]  rob_entry;
  logic [5:0]  rob_des;
  logic [31:0] rob_result, pc_redirect;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.ENTRY_SIZE(4), .NULL_REG(NULL_REG)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .rob_full(rob_full), .rob_new_entry(rob_new_entry),
    .rs_broadcast(rs_broadcast), .rs_entry(rs_entry), .rs_result(rs_result), .rs_taken(rs_taken),
    .lsb_broadcast(lsb_broadcast), .lsb_entry(lsb_entry), .lsb_result(lsb_result),
    .qj_in(qj_in), .qk_in(qk_in), .qj_ready(qj_ready), .qk_ready(qk_ready),
    .qj_value(qj_value), .qk_value(qk_value),
    .rob_commit(rob_commit), .rob_entry(rob_entry), .rob_des(rob_des), .rob_result(rob_result),
    .store_commit(store_commit), .roll_back(roll_back), .pc_redirect(pc_redirect)
  );

  // Reference model: program-order queue of live instructions.
  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  typ;
    logic [5:0]  rd;
    logic        pred;
    logic [31:0] alt;
    logic        rdy;
    logic [31:0] res;
    logic        tk;
  } ent_t;

  ent_t       q[$];
  logic [3:0] m_tail;

  logic        exp_commit, exp_roll, exp_store, exp_full;
  logic [3:0]  exp_entry, exp_new;
  logic [5:0]  exp_des;
  logic [31:0] exp_result, exp_pc;

  task automatic clear_inputs();
    rdy_in = 1'b1; issue_valid = 1'b0; issue_type = 2'd0; issue_rd = NULL_REG;
    issue_pred_taken = 1'b0; issue_alt_pc = '0;
    rs_broadcast = 1'b0; rs_entry = '0; rs_result = '0; rs_taken = 1'b0;
    lsb_broadcast = 1'b0; lsb_entry = '0; lsb_result = '0;
    qj_in = '0; qk_in = '0;
  endtask

  task automatic model_reset();
    q.delete();
    m_tail = 4'd1;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
    model_reset();
  endtask

  // Expected combinational query answer from the model and the current inputs.
  task automatic predict_query(input logic [3:0] t, output logic r, output logic [31:0] v);
    r = 1'b0; v = '0;
    if (t != 0) begin
      foreach (q[i]) if (q[i].tag == t && q[i].rdy) begin r = 1'b1; v = q[i].res; end
      if (!r && rs_broadcast && rs_entry == t) begin r = 1'b1; v = rs_result; end
      else if (!r && lsb_broadcast && lsb_entry == t) begin r = 1'b1; v = lsb_result; end
    end
  endtask

  // Advance model and DUT by one clock; leaves expectations for the edge just taken.
  task automatic tick();
    ent_t e, e2;
    bit   commit, mis, full;
    exp_commit = 1'b0; exp_roll = 1'b0; exp_store = 1'b0;
    if (rdy_in) begin
      commit = (q.size() > 0) && q[0].rdy;
      mis = 1'b0;
      if (commit) begin
        e = q[0];
        exp_commit = 1'b1;
        exp_entry  = e.tag;
        exp_des    = (e.typ == 2'd1 || e.typ == 2'd2) ? NULL_REG : e.rd;
        exp_result = e.res;
        exp_store  = (e.typ == 2'd2);
        mis = (e.typ == 2'd1) && (e.tk != e.pred);
        if (mis) begin exp_roll = 1'b1; exp_pc = e.alt; end
      end
      if (mis) begin
        q.delete();
        m_tail = 4'd1;
      end else begin
        full = (q.size() == 15);
        foreach (q[i]) begin
          e2 = q[i];
          if (rs_broadcast && e2.tag == rs_entry) begin e2.rdy = 1'b1; e2.res = rs_result; e2.tk = rs_taken; end
          if (lsb_broadcast && e2.tag == lsb_entry) begin e2.rdy = 1'b1; e2.res = lsb_result; end
          q[i] = e2;
        end
        if (issue_valid && !full) begin
          e2.tag = m_tail; e2.typ = issue_type; e2.rd = issue_rd; e2.pred = issue_pred_taken;
          e2.alt = issue_alt_pc; e2.rdy = 1'b0; e2.res = '0; e2.tk = 1'b0;
          q.push_back(e2);
          m_tail = (m_tail == 4'd15) ? 4'd1 : m_tail + 4'd1;
        end
        if (commit) void'(q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    exp_full = (q.size() == 15);
    exp_new  = m_tail;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_in = 1'b1;
    #2;
    checks++; if (rob_commit !== 1'b0) begin errors++; $display("FAIL reset_commit: got %0b want 0", rob_commit); end
    checks++; if (store_commit !== 1'b0) begin errors++; $display("FAIL reset_store: got %0b want 0", store_commit); end
    checks++; if (roll_back !== 1'b0) begin errors++; $display("FAIL reset_roll: got %0b want 0", roll_back); end
    checks++; if (rob_entry !== 4'd0) begin errors++; $display("FAIL reset_entry: got %0h want 0", rob_entry); end
    checks++; if (rob_des !== NULL_REG) begin errors++; $display("FAIL reset_des: got %0d want 32", rob_des); end
    checks++; if (rob_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %0h want 0", rob_result); end
    checks++; if (pc_redirect !== 32'd0) begin errors++; $display("FAIL reset_pc: got %0h want 0", pc_redirect); end
    checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", rob_full); end
    checks++; if (rob_new_entry !== 4'd1) begin errors++; $display("FAIL reset_new_entry: got %0h want 1", rob_new_entry); end
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic test_in_order();
    reset_dut();
    issue_valid = 1'b1; issue_type = 2'd0; issue_rd = 6'd5; tick();
    issue_rd = 6'd6; tick();
    issue_valid = 1'b0;
    checks++; if (rob_new_entry !== 4'd3) begin errors++; $display("FAIL order_tail: got %0h want 3", rob_new_entry); end
    lsb_broadcast = 1'b1; lsb_entry = 4'd2; lsb_result = 32'h22; tick();
    lsb_broadcast = 1'b0;
    checks++; if (rob_commit !== 1'b0) begin errors++; $display("FAIL order_no_early_commit: got %0b want 0", rob_commit); end
    rs_broadcast = 1'b1; rs_entry = 4'd1; rs_result = 32'h11; tick();
    rs_broadcast = 1'b0;
    checks++; if (rob_commit !== 1'b0) begin errors++; $display("FAIL order_latency: got %0b want 0", rob_commit); end
    tick();
    checks++; if ({rob_commit, rob_entry, rob_des, rob_result} !== {1'b1, 4'd1, 6'd5, 32'h11})
      begin errors++; $display("FAIL order_first: got c=%0b t=%0h d=%0d r=%0h want c=1 t=1 d=5 r=11", rob_commit, rob_entry, rob_des, rob_result); end
    tick();
    checks++; if ({rob_commit, rob_entry, rob_des, rob_result} !== {1'b1, 4'd2, 6'd6, 32'h22})
      begin errors++; $display("FAIL order_second: got c=%0b t=%0h d=%0d r=%0h want c=1 t=2 d=6 r=22", rob_commit, rob_entry, rob_des, rob_result); end
    tick();
    checks++; if (rob_commit !== 1'b0) begin errors++; $display("FAIL order_drained: got %0b want 0", rob_commit); end
  endtask

  task automatic test_full_wrap();
    reset_dut();
    issue_valid = 1'b1; issue_type = 2'd0;
    for (int i = 0; i < 15; i++) begin issue_rd = 6'(i); tick(); end
    checks++; if ({rob_full, rob_new_entry} !== {1'b1, 4'd1}) begin errors++; $display("FAIL full_set: got full=%0b tail=%0h want full=1 tail=1", rob_full, rob_new_entry); end
    issue_rd = 6'd20; tick();
    checks++; if ({rob_full, rob_new_entry} !== {1'b1, 4'd1}) begin errors++; $display("FAIL full_ignore: got full=%0b tail=%0h want full=1 tail=1", rob_full, rob_new_entry); end
    issue_valid = 1'b0;
    rs_broadcast = 1'b1; rs_entry = 4'd1; rs_result = 32'h1; tick();
    rs_broadcast = 1'b0;
    tick();
    checks++; if ({rob_commit, rob_entry, rob_full, rob_new_entry} !== {1'b1, 4'd1, 1'b0, 4'd1})
      begin errors++; $display("FAIL full_commit: got c=%0b t=%0h full=%0b tail=%0h want c=1 t=1 full=0 tail=1", rob_commit, rob_entry, rob_full, rob_new_entry); end
    issue_valid = 1'b1; issue_rd = 6'd9; tick();
    issue_valid = 1'b0;
    checks++; if ({rob_full, rob_new_entry} !== {1'b1, 4'd2}) begin errors++; $display("FAIL full_wrap_issue: got full=%0b tail=%0h want full=1 tail=2", rob_full, rob_new_entry); end
  endtask

  task automatic test_mispredict();
    reset_dut();
    issue_valid = 1'b1; issue_type = 2'd1; issue_pred_taken = 1'b0; issue_alt_pc = 32'h100; tick();
    issue_type = 2'd0; issue_pred_taken = 1'b0; issue_alt_pc = '0;
    for (int i = 1; i <= 3; i++) begin issue_rd = 6'(i); tick(); end
    issue_valid = 1'b0;
    rs_broadcast = 1'b1; rs_entry = 4'd1; rs_taken = 1'b1; rs_result = 32'hBB;
    lsb_broadcast = 1'b1; lsb_entry = 4'd2; lsb_result = 32'h22; tick();
    lsb_broadcast = 1'b0;
    issue_valid = 1'b1; issue_rd = 6'd4; rs_entry = 4'd3; rs_taken = 1'b0; tick();
    clear_inputs();
    checks++; if ({rob_commit, roll_back, rob_entry, rob_des, pc_redirect} !== {1'b1, 1'b1, 4'd1, NULL_REG, 32'h100})
      begin errors++; $display("FAIL mispredict_flush: got c=%0b rb=%0b t=%0h d=%0d pc=%0h want c=1 rb=1 t=1 d=32 pc=100", rob_commit, roll_back, rob_entry, rob_des, pc_redirect); end
    checks++; if ({rob_full, rob_new_entry} !== {1'b0, 4'd1}) begin errors++; $display("FAIL mispredict_empty: got full=%0b tail=%0h want full=0 tail=1", rob_full, rob_new_entry); end
    tick();
    checks++; if ({rob_commit, roll_back, rob_new_entry} !== {1'b0, 1'b0, 4'd1})
      begin errors++; $display("FAIL mispredict_after: got c=%0b rb=%0b tail=%0h want c=0 rb=0 tail=1", rob_commit, roll_back, rob_new_entry); end
  endtask

  task automatic test_query_bypass();
    reset_dut();
    issue_valid = 1'b1; issue_type = 2'd0;
    for (int i = 0; i < 3; i++) begin issue_rd = 6'(i + 10); tick(); end
    issue_valid = 1'b0;
    rs_broadcast = 1'b1; rs_entry = 4'd3; rs_result = 32'hAB; qj_in = 4'd3; qk_in = 4'd0;
    #1;
    checks++; if ({qj_ready, qj_value} !== {1'b1, 32'hAB}) begin errors++; $display("FAIL query_rs_bypass: got r=%0b v=%0h want r=1 v=ab", qj_ready, qj_value); end
    checks++; if ({qk_ready, qk_value} !== {1'b0, 32'h0}) begin errors++; $display("FAIL query_tag0: got r=%0b v=%0h want r=0 v=0", qk_ready, qk_value); end
    tick();
    rs_broadcast = 1'b0; qk_in = 4'd2;
    #1;
    checks++; if ({qj_ready, qj_value} !== {1'b1, 32'hAB}) begin errors++; $display("FAIL query_stored: got r=%0b v=%0h want r=1 v=ab", qj_ready, qj_value); end
    checks++; if (qk_ready !== 1'b0) begin errors++; $display("FAIL query_not_ready: got %0b want 0", qk_ready); end
    lsb_broadcast = 1'b1; lsb_entry = 4'd2; lsb_result = 32'h5A;
    #1;
    checks++; if ({qk_ready, qk_value} !== {1'b1, 32'h5A}) begin errors++; $display("FAIL query_lsb_bypass: got r=%0b v=%0h want r=1 v=5a", qk_ready, qk_value); end
    rs_broadcast = 1'b1; rs_entry = 4'd2; rs_result = 32'h77;
    #1;
    checks++; if ({qk_ready, qk_value} !== {1'b1, 32'h77}) begin errors++; $display("FAIL query_rs_priority: got r=%0b v=%0h want r=1 v=77", qk_ready, qk_value); end
    rs_broadcast = 1'b0; lsb_broadcast = 1'b0;
    tick();
  endtask

  task automatic test_store_stall();
    reset_dut();
    issue_valid = 1'b1; issue_type = 2'd2; issue_rd = 6'd7; tick();
    issue_valid = 1'b0;
    lsb_broadcast = 1'b1; lsb_entry = 4'd1; lsb_result = 32'h77; tick();
    lsb_broadcast = 1'b0;
    rdy_in = 1'b0; issue_valid = 1'b1; issue_type = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({rob_commit, store_commit, rob_new_entry} !== {1'b0, 1'b0, 4'd2})
        begin errors++; $display("FAIL stall_frozen[%0d]: got c=%0b s=%0b tail=%0h want c=0 s=0 tail=2", i, rob_commit, store_commit, rob_new_entry); end
    end
    rdy_in = 1'b1; issue_valid = 1'b0; tick();
    checks++; if ({rob_commit, store_commit, rob_entry, rob_des, rob_result} !== {1'b1, 1'b1, 4'd1, NULL_REG, 32'h77})
      begin errors++; $display("FAIL store_commit: got c=%0b s=%0b t=%0h d=%0d r=%0h want c=1 s=1 t=1 d=32 r=77", rob_commit, store_commit, rob_entry, rob_des, rob_result); end
  endtask

  task automatic test_random();
    logic        er_j, er_k;
    logic [31:0] ev_j, ev_k;
    bit          is_branch;
    reset_dut();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      issue_valid = $urandom_range(0, 1);
      issue_type = 2'($urandom_range(0, 2));
      issue_rd = 6'($urandom_range(0, 32));
      issue_pred_taken = $urandom_range(0, 1);
      issue_alt_pc = $urandom;
      rs_broadcast = ($urandom_range(0, 9) < 4);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) rs_entry = q[$urandom_range(0, q.size() - 1)].tag;
      else rs_entry = 4'($urandom_range(1, 15));
      rs_result = $urandom;
      rs_taken = 1'b0;
      foreach (q[i]) if (q[i].tag == rs_entry)
        rs_taken = ($urandom_range(0, 3) == 0) ? ~q[i].pred : q[i].pred;
      lsb_broadcast = ($urandom_range(0, 9) < 4);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) lsb_entry = q[$urandom_range(0, q.size() - 1)].tag;
      else lsb_entry = 4'($urandom_range(1, 15));
      lsb_result = $urandom;
      is_branch = 1'b0;
      foreach (q[i]) if (q[i].tag == lsb_entry && q[i].typ == 2'd1) is_branch = 1'b1;
      if (is_branch || (rs_broadcast && rs_entry == lsb_entry)) lsb_broadcast = 1'b0;
      qj_in = 4'($urandom_range(0, 15));
      qk_in = 4'($urandom_range(0, 15));
      #1;
      predict_query(qj_in, er_j, ev_j);
      predict_query(qk_in, er_k, ev_k);
      checks++; if ({qj_ready, qj_value} !== {er_j, ev_j}) begin errors++; $display("FAIL rnd_qj[%0d]: got r=%0b v=%0h want r=%0b v=%0h", cyc, qj_ready, qj_value, er_j, ev_j); end
      checks++; if ({qk_ready, qk_value} !== {er_k, ev_k}) begin errors++; $display("FAIL rnd_qk[%0d]: got r=%0b v=%0h want r=%0b v=%0h", cyc, qk_ready, qk_value, er_k, ev_k); end
      tick();
      checks++; if ({rob_commit, store_commit, roll_back, rob_full, rob_new_entry} !== {exp_commit, exp_store, exp_roll, exp_full, exp_new})
        begin errors++; $display("FAIL rnd_ctrl[%0d]: got c=%0b s=%0b rb=%0b f=%0b t=%0h want c=%0b s=%0b rb=%0b f=%0b t=%0h", cyc,
          rob_commit, store_commit, roll_back, rob_full, rob_new_entry, exp_commit, exp_store, exp_roll, exp_full, exp_new); end
      if (exp_commit) begin
        checks++; if ({rob_entry, rob_des, rob_result} !== {exp_entry, exp_des, exp_result})
          begin errors++; $display("FAIL rnd_data[%0d]: got t=%0h d=%0d r=%0h want t=%0h d=%0d r=%0h", cyc, rob_entry, rob_des, rob_result, exp_entry, exp_des, exp_result); end
      end
      if (exp_roll) begin
        checks++; if (pc_redirect !== exp_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %0h want %0h", cyc, pc_redirect, exp_pc); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    reset_dut();
    issue_valid = 1'b1; issue_type = 2'd0;
    for (int i = 0; i < 5; i++) begin issue_rd = 6'(i + 1); tick(); end
    issue_valid = 1'b0;
    rs_broadcast = 1'b1; rs_entry = 4'd1; rs_result = 32'hA1;
    lsb_broadcast = 1'b1; lsb_entry = 4'd2; lsb_result = 32'hA2; tick();
    rs_entry = 4'd3; rs_result = 32'hA3; lsb_entry = 4'd4; lsb_result = 32'hA4; tick();
    lsb_broadcast = 1'b0;
    rs_entry = 4'd5; rs_result = 32'hA5; tick();
    rs_broadcast = 1'b0;
    checks++; if ({rob_commit, rob_entry} !== {1'b1, 4'd2}) begin errors++; $display("FAIL areset_pre: got c=%0b t=%0h want c=1 t=2", rob_commit, rob_entry); end
    #2;
    rst_in = 1'b1;
    #1;
    checks++; if ({rob_commit, roll_back, store_commit, rob_entry, rob_des, rob_result, pc_redirect, rob_full, rob_new_entry}
                  !== {1'b0, 1'b0, 1'b0, 4'd0, NULL_REG, 32'd0, 32'd0, 1'b0, 4'd1})
      begin errors++; $display("FAIL areset_immediate: got c=%0b t=%0h d=%0d r=%0h pc=%0h f=%0b tail=%0h", rob_commit, rob_entry, rob_des, rob_result, pc_redirect, rob_full, rob_new_entry); end
    #2;
    rst_in = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rob_commit !== 1'b0) begin errors++; $display("FAIL areset_no_commit[%0d]: got %0b want 0", i, rob_commit); end
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full_wrap();
    test_mispredict();
    test_query_bypass();
    test_store_stall();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
